// File: rtl/sha256_core.sv
// Single-block SHA-256 compression engine: 16-word load, 64 rounds at one per clock, digest accumulate.
// Build option SHA256_CORE_CHAIN_EN: keep H across blocks (multi-block messages); otherwise reload IV per block.
module sha256_core (
   input  logic         clk,
   input  logic         resetn,
   input  logic [31:0]  data,
   input  logic         wr_en,
   output logic         wr_ready,
   output logic         blk_ready,
   output logic [255:0] hash
);

   typedef enum logic [1:0] {LOAD, COMPRESS, FINAL} state_t;

   localparam logic [0:7][31:0] IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam logic [0:63][31:0] K = {
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   state_t            state, state_nxt;
   logic [3:0]        cnt;
   logic [5:0]        t;
   logic [0:15][31:0] w;     // w[0] always holds W[t]
   logic [0:7][31:0]  wv;    // working vars a..h
   logic [0:7][31:0]  hv;    // H0..H7
   logic [31:0]       t1, t2, w_new;
   logic              accept;

   assign accept = wr_en && wr_ready;
   assign hash   = hv;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= LOAD;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      wr_ready  = 1'b0;
      case (state)
         LOAD: begin
            wr_ready = 1'b1;
            if (accept && cnt == 4'd15) state_nxt = COMPRESS;
         end
         COMPRESS: if (t == 6'd63) state_nxt = FINAL;
         FINAL:    state_nxt = LOAD;
         default:  state_nxt = LOAD;
      endcase
   end

   always_comb begin
      t1 = wv[7] + bsig1(wv[4]) + ((wv[4] & wv[5]) ^ (~wv[4] & wv[6])) + K[t] + w[0];
      t2 = bsig0(wv[0]) + ((wv[0] & wv[1]) ^ (wv[0] & wv[2]) ^ (wv[1] & wv[2]));
      // Next schedule word W[t+16] from the window W[t..t+15]
      w_new = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt       <= '0;
         t         <= '0;
         w         <= '0;
         wv        <= '0;
         hv        <= IV;
         blk_ready <= 1'b0;
      end else begin
         case (state)
            LOAD: if (accept) begin
               w[cnt] <= data;
               cnt    <= cnt + 4'd1;
               if (cnt == 4'd0) begin
                  blk_ready <= 1'b0;
`ifndef SHA256_CORE_CHAIN_EN
                  hv <= IV;
`endif
               end
               if (cnt == 4'd15) begin
`ifdef SHA256_CORE_CHAIN_EN
                  wv <= hv;
`else
                  // H was just reset to IV by word 0 of this block
                  wv <= IV;
`endif
                  t  <= '0;
               end
            end
            COMPRESS: begin
               wv <= {t1 + t2, wv[0:2], wv[3] + t1, wv[4:6]};
               w  <= {w[1:15], w_new};
               t  <= t + 6'd1;
            end
            FINAL: begin
               for (int i = 0; i < 8; i++) hv[i] <= hv[i] + wv[i];
               blk_ready <= 1'b1;
               cnt       <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_core.sv
// Directed-vector bench for sha256_core: known digests, handshake timing, async reset mid-compress.
module tb_sha256_core;

   logic         clk = 1'b0;
   logic         resetn;
   logic [31:0]  data;
   logic         wr_en;
   logic         wr_ready;
   logic         blk_ready;
   logic [255:0] hash;

   int n_chk = 0;
   int n_err = 0;
   logic [31:0] blk [16];

   localparam logic [255:0] IV_H    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam logic [255:0] HELLO_H = 256'hb94d27b9934d3e08a52e52d7da7dabfac484efe37a5380ee9088f7ace2efcde9;
   localparam logic [255:0] ABC_H   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] EMPTY_H = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [255:0] TWO_H   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

   sha256_core dut (
      .clk       (clk),
      .resetn    (resetn),
      .data      (data),
      .wr_en     (wr_en),
      .wr_ready  (wr_ready),
      .blk_ready (blk_ready),
      .hash      (hash)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0;
      wr_en  = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic fill_hello();
      for (int i = 0; i < 16; i++) blk[i] = 32'h0;
      blk[0] = 32'h68656C6C; blk[1] = 32'h6F20776F; blk[2] = 32'h726C6480;
      blk[15] = 32'h00000058;
   endtask

   task automatic fill_abc();
      for (int i = 0; i < 16; i++) blk[i] = 32'h0;
      blk[0] = 32'h61626380; blk[15] = 32'h00000018;
   endtask

   // Writes blk[0..15]; returns at the negedge right after the 16th word's edge.
   // hold keeps wr_en asserted with junk data afterwards.
   task automatic send_block(input bit gap, input bit hold);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         wr_en = 1'b1;
         data  = blk[i];
         if (gap && i < 15) begin
            @(negedge clk);
            wr_en = 1'b0;
            data  = 32'hx;
         end
      end
      @(negedge clk);
      wr_en = hold;
      data  = 32'hdeadbeef;
   endtask

   // Called after edge E; checks FINAL lands on E+65 and drops any held wr_en there.
   task automatic wait_digest(input string tag);
      for (int k = 1; k <= 64; k++) begin
         if (k == 1 || k == 40) chk({tag, "_wr_ready_busy"}, {255'b0, wr_ready}, 256'd0);
         @(negedge clk);
      end
      chk({tag, "_blk_ready_early"}, {255'b0, blk_ready}, 256'd0);
      @(negedge clk);
      wr_en = 1'b0;
      chk({tag, "_blk_ready"}, {255'b0, blk_ready}, 256'd1);
      chk({tag, "_wr_ready"},  {255'b0, wr_ready},  256'd1);
   endtask

   initial begin
      resetn = 1'b0;
      wr_en  = 1'b0;
      data   = 32'h0;
      repeat (2) @(negedge clk);
      chk("rst_wr_ready",  {255'b0, wr_ready},  256'd1);
      chk("rst_blk_ready", {255'b0, blk_ready}, 256'd0);
      chk("rst_hash",      hash, IV_H);
      resetn = 1'b1;

      // "hello world" with idle cycles between words
      fill_hello();
      send_block(1'b1, 1'b0);
      wait_digest("hello");
      chk("hello_hash", hash, HELLO_H);

      // "abc" back-to-back, wr_en held high through COMPRESS
      do_reset();
      fill_abc();
      send_block(1'b0, 1'b1);
      wait_digest("abc_hold");
      chk("abc_hash", hash, ABC_H);

      // Empty message: first word must clear blk_ready; a miscounted cnt would corrupt the digest
      for (int i = 0; i < 16; i++) blk[i] = 32'h0;
      blk[0] = 32'h80000000;
      @(negedge clk);
      wr_en = 1'b1;
      data  = blk[0];
      @(negedge clk);
      wr_en = 1'b0;
      chk("word0_clears_blk_ready", {255'b0, blk_ready}, 256'd0);
`ifndef SHA256_CORE_CHAIN_EN
      chk("word0_reloads_iv", hash, IV_H);
`endif
      for (int i = 1; i < 16; i++) begin
         @(negedge clk);
         wr_en = 1'b1;
         data  = blk[i];
      end
      @(negedge clk);
      wr_en = 1'b0;
      wait_digest("empty");
`ifndef SHA256_CORE_CHAIN_EN
      chk("empty_hash", hash, EMPTY_H);
`endif

      // Async reset in the middle of compression
      do_reset();
      fill_hello();
      send_block(1'b0, 1'b0);
      repeat (30) @(negedge clk);
      resetn = 1'b0;
      #1;
      chk("midrst_hash",      hash, IV_H);
      chk("midrst_wr_ready",  {255'b0, wr_ready},  256'd1);
      chk("midrst_blk_ready", {255'b0, blk_ready}, 256'd0);
      @(negedge clk);
      resetn = 1'b1;
      fill_abc();
      send_block(1'b0, 1'b0);
      wait_digest("abc_after_rst");
      chk("abc_after_rst_hash", hash, ABC_H);

`ifdef SHA256_CORE_CHAIN_EN
      do_reset();
      blk[0]  = 32'h61626364; blk[1]  = 32'h62636465; blk[2]  = 32'h63646566; blk[3]  = 32'h64656667;
      blk[4]  = 32'h65666768; blk[5]  = 32'h66676869; blk[6]  = 32'h6768696a; blk[7]  = 32'h68696a6b;
      blk[8]  = 32'h696a6b6c; blk[9]  = 32'h6a6b6c6d; blk[10] = 32'h6b6c6d6e; blk[11] = 32'h6c6d6e6f;
      blk[12] = 32'h6d6e6f70; blk[13] = 32'h6e6f7071; blk[14] = 32'h80000000; blk[15] = 32'h00000000;
      send_block(1'b0, 1'b0);
      wait_digest("chain_b1");
      for (int i = 0; i < 16; i++) blk[i] = 32'h0;
      blk[15] = 32'h000001c0;
      send_block(1'b0, 1'b0);
      wait_digest("chain_b2");
      chk("chain_hash", hash, TWO_H);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/sha256_core.md
# sha256_core

Single-block SHA-256 compression engine. Accepts a pre-padded 512-bit message block as sixteen 32-bit words over a simple write handshake, runs the 64 compression rounds at one round per clock, and presents the 256-bit digest. Padding and length encoding are done upstream; this block only performs FIPS 180-4 compression and digest accumulation.

## Interface
Parameters: none.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- data  in  32  message word; word 0 first, big-endian (data = W[t])
- wr_en  in  1  write strobe; a word is accepted on a rising edge when wr_en && wr_ready
- wr_ready  out  1  core can accept a word
- blk_ready  out  1  digest for the last block is valid on hash
- hash  out  256  H0..H7 concatenated; hash[255:224]=H0, hash[31:0]=H7

## Operation
- States: LOAD, COMPRESS, FINAL.
- LOAD: wr_ready=1. Each accepted word is written to schedule slot cnt, then cnt++ (4-bit). The first accepted word of a block clears blk_ready. When the 16th word (cnt=15) is accepted: working registers a..h <= H0..H7, round t <= 0, state -> COMPRESS.
- COMPRESS: wr_ready=0; wr_en is ignored. One round per cycle, t=0..63, standard T1/T2 update with K[t] from a 64-entry constant ROM. Message schedule is a 16-word shift window: W[t] is the window head for t<16; for t>=16, W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16]. The window shifts every round. All additions are mod 2^32. After t=63: state -> FINAL.
- FINAL (1 cycle): Hi <= Hi + working var (mod 2^32), blk_ready <= 1, cnt <= 0, state -> LOAD.
- blk_ready stays high until the next accepted word. hash always reflects the H registers.
- Reset (asynchronous, at any time, including mid-COMPRESS): state=LOAD, cnt=0, t=0, wr_ready=1, blk_ready=0, H = IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19). The partial block is discarded.

## Timing
- Writes may be back-to-back, one per cycle, or have arbitrary gaps; there is no timeout.
- The 16th word is accepted at edge E. Rounds execute at edges E+1..E+64. FINAL executes at edge E+65, so blk_ready and wr_ready read 1 after edge E+65.
- wr_ready falls after edge E and rises together with blk_ready.
- Minimum block period: 16 load cycles + 65 cycles.
- A wr_en asserted in the same cycle that wr_ready returns high is accepted as word 0 of the next block.

## Configuration
- SHA256_CORE_CHAIN_EN defined: H is not reinitialised between blocks. Each block chains from the previous digest, which supports multi-block messages. Only reset restores IV.
- SHA256_CORE_CHAIN_EN undefined: H is reloaded with IV when word 0 of each block is accepted. Each block is then hashed as an independent single-block message.

## Test plan
- Reset: hold resetn=0 -> wr_ready=1, blk_ready=0, hash=6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19.
- "hello world": words 68656C6C, 6F20776F, 726C6480, 0×12, 00000058, written with 1-cycle gaps -> blk_ready 65 cycles after the last write edge; hash=b94d27b9934d3e08a52e52d7da7dabfac484efe37a5380ee9088f7ace2efcde9.
- "abc" back-to-back: words 61626380, 0×14, 00000018 -> hash=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad. Empty message (80000000, 0×15) with chaining disabled -> e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- Handshake: hold wr_en=1 through COMPRESS -> no words accepted and cnt unchanged while wr_ready=0. The first write after the digest clears blk_ready.
- Mid-compress reset: assert resetn=0 at round 30 -> IV restored and LOAD entered. Reload "abc" -> correct digest.
- Chaining (SHA256_CORE_CHAIN_EN): the two padded blocks of "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" -> 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
